// File: rtl/mc_ctrl_fsm_if.sv
// Memory handshake between the control FSM and the memory port.
// Master drives the request/strobe, slave answers with mem_ready.
interface mc_ctrl_fsm_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    output mem_ready
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multicycle CPU control FSM with memory wait states and halt.
// Optional memory timeout: define CTRL_FSM_TIMEOUT_EN.
module mc_ctrl_fsm #(
  parameter int INSTR_W = 16,
  parameter int FLAG_W  = 5,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instruction,
  input  logic [FLAG_W-1:0]  psr_flags,
  input  logic               halt_req,
  mc_ctrl_fsm_if.master      mem,
  output logic               pc_en,
  output logic               pc_inc_or_set,
  output logic               ir_en,
  output logic               rf_we,
  output logic               pc_reg_sel,
  output logic               r2_im_sel,
  output logic [1:0]         imm_type_sel,
  output logic               wb_reg_alu,
  output logic               psr_en,
  output logic [2:0]         state,
  output logic               timeout_err
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } st_t;

  st_t st_q, st_d;
  logic [CNT_W-1:0] cnt;
  logic req, we, to_hit;

  logic [3:0] op, cond, ext;
  assign op   = instruction[15:12];
  assign cond = instruction[11:8];
  assign ext  = instruction[7:4];

  logic unused_ok;
  assign unused_ok = ^{instruction, psr_flags};

  logic fn, fz, ff, fl, fc;
  assign fn = psr_flags[4];
  assign fz = psr_flags[3];
  assign ff = psr_flags[2];
  assign fl = psr_flags[1];
  assign fc = psr_flags[0];

  logic is_ld, is_st, is_jc, is_bc;
  logic is_cmp, is_cmpi, is_r;
  logic is_lg, is_ar, is_sh;
  assign is_ld   = (op == 4'h4) && (ext == 4'h0);
  assign is_st   = (op == 4'h4) && (ext == 4'h4);
  assign is_jc   = (op == 4'h4) && (ext == 4'hC);
  assign is_bc   = (op == 4'hC);
  assign is_cmp  = (op == 4'h0) && (ext == 4'hB);
  assign is_cmpi = (op == 4'hB);
  assign is_r    = (op == 4'h0);
  assign is_lg   = (op == 4'h1) || (op == 4'h2) ||
                   (op == 4'h3) || (op == 4'hD);
  assign is_ar   = (op == 4'h5) || (op == 4'h9) ||
                   (op == 4'hB);
  assign is_sh   = (op == 4'h8) || (op == 4'hF);

  logic tk;
  always_comb begin
    case (cond)
      4'h0: tk = fz;
      4'h1: tk = !fz;
      4'h2: tk = fc;
      4'h3: tk = !fc;
      4'h4: tk = fl;
      4'h5: tk = !fl;
      4'h6: tk = fn;
      4'h7: tk = !fn;
      4'h8: tk = ff;
      4'h9: tk = !ff;
      4'hA: tk = !fl && !fz;
      4'hB: tk = fl || fz;
      4'hC: tk = !fn && !fz;
      4'hD: tk = fn || fz;
      4'hE: tk = 1'b1;
      default: tk = 1'b0;
    endcase
  end

`ifdef CTRL_FSM_TIMEOUT_EN
  assign to_hit = (cnt == CNT_W'(TIMEOUT)) &&
                  !mem.mem_ready;
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    st_d          = st_q;
    pc_en         = 1'b0;
    pc_inc_or_set = 1'b0;
    ir_en         = 1'b0;
    rf_we         = 1'b0;
    pc_reg_sel    = 1'b1;
    r2_im_sel     = 1'b0;
    imm_type_sel  = 2'b00;
    wb_reg_alu    = 1'b1;
    psr_en        = 1'b0;
    req           = 1'b0;
    we            = 1'b0;
    case (st_q)
      FETCH: begin
        req = 1'b1;
        if (to_hit) begin
          req  = 1'b0;
          st_d = HALT;
        end else if (mem.mem_ready) begin
          st_d = DECODE;
        end
      end
      DECODE: begin
        ir_en = 1'b1;
        st_d  = EXEC;
      end
      EXEC: begin
        psr_en = !((op == 4'h4) || is_bc);
        unique case (1'b1)
          is_r: r2_im_sel = 1'b0;
          is_lg: begin
            r2_im_sel    = 1'b1;
            imm_type_sel = 2'b10;
          end
          is_ar: begin
            r2_im_sel    = 1'b1;
            imm_type_sel = 2'b01;
          end
          is_sh: begin
            r2_im_sel    = 1'b1;
            imm_type_sel = 2'b00;
          end
          is_bc: begin
            pc_reg_sel   = 1'b0;
            r2_im_sel    = 1'b1;
            imm_type_sel = 2'b01;
          end
          is_jc: imm_type_sel = 2'b11;
          default: ;
        endcase
        st_d = (is_ld || is_st) ? MEM : WB;
      end
      MEM: begin
        req = 1'b1;
        we  = is_st;
        if (to_hit) begin
          req  = 1'b0;
          we   = 1'b0;
          st_d = HALT;
        end else if (mem.mem_ready) begin
          st_d = WB;
        end
      end
      WB: begin
        pc_en = 1'b1;
        rf_we = !(is_st || is_bc || is_jc ||
                  is_cmp || is_cmpi);
        wb_reg_alu    = !is_ld;
        pc_inc_or_set = (is_bc || is_jc) && tk;
        st_d = halt_req ? HALT : FETCH;
      end
      HALT: begin
        if (!halt_req && !timeout_err)
          st_d = FETCH;
      end
      default: st_d = FETCH;
    endcase
  end

  assign mem.mem_req = req;
  assign mem.mem_we  = we;
  assign state       = st_q;

  always_ff @(posedge clock) begin
    if (!reset) st_q <= FETCH;
    else        st_q <= st_d;
  end

  // Counter restarts whenever a new memory access begins.
  always_ff @(posedge clock) begin
    if (!reset)
      cnt <= '0;
    else if ((st_d != st_q) &&
             ((st_d == FETCH) || (st_d == MEM)))
      cnt <= '0;
    else if (req && !mem.mem_ready && (cnt != '1))
      cnt <= cnt + 1'b1;
  end

`ifdef CTRL_FSM_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (!reset)
      timeout_err <= 1'b0;
    else if (to_hit &&
             ((st_q == FETCH) || (st_q == MEM)))
      timeout_err <= 1'b1;
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed self-checking bench for mc_ctrl_fsm.
// Timeout section active with CTRL_FSM_TIMEOUT_EN.
module tb_mc_ctrl_fsm;

`ifdef CTRL_FSM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clock;
  logic        reset;
  logic [15:0] instruction;
  logic [4:0]  psr_flags;
  logic        halt_req;
  logic        mem_ready;
  logic        pc_en, pc_inc_or_set, ir_en, rf_we;
  logic        pc_reg_sel, r2_im_sel, wb_reg_alu;
  logic        psr_en, timeout_err;
  logic [1:0]  imm_type_sel;
  logic [2:0]  state;

  mc_ctrl_fsm_if mif ();
  assign mif.mem_ready = mem_ready;

  mc_ctrl_fsm #(.TIMEOUT(TO)) dut (
    .clock         (clock),
    .reset         (reset),
    .instruction   (instruction),
    .psr_flags     (psr_flags),
    .halt_req      (halt_req),
    .mem           (mif),
    .pc_en         (pc_en),
    .pc_inc_or_set (pc_inc_or_set),
    .ir_en         (ir_en),
    .rf_we         (rf_we),
    .pc_reg_sel    (pc_reg_sel),
    .r2_im_sel     (r2_im_sel),
    .imm_type_sel  (imm_type_sel),
    .wb_reg_alu    (wb_reg_alu),
    .psr_en        (psr_en),
    .state         (state),
    .timeout_err   (timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  int         cyc, mreq_n, irn;
  logic       mwe;
  logic [1:0] ex_imm;
  logic       ex_psr, ex_r2, ex_pcsel;
  logic       wb_rf, wb_set, wb_alu, wb_pcen;

  task chk(input string tag,
           input logic [31:0] got,
           input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task step;
    @(posedge clock);
    #1;
  endtask

  // Runs one instruction from FETCH through WB.
  task run(input logic [15:0] ins,
           input logic [4:0]  fl,
           input int          mwait,
           input logic        hreq);
    int w;
    logic done;
    instruction = ins;
    psr_flags   = fl;
    halt_req    = hreq;
    cyc = 0; mreq_n = 0; irn = 0; mwe = 1'b0;
    w = 0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      mem_ready = 1'b1;
      if (state == 3'd3) begin
        mem_ready = (w >= mwait);
        w++;
        if (mif.mem_req) mreq_n++;
        if (mif.mem_we) mwe = 1'b1;
      end
      if (ir_en) irn++;
      if (state == 3'd2) begin
        ex_imm   = imm_type_sel;
        ex_psr   = psr_en;
        ex_r2    = r2_im_sel;
        ex_pcsel = pc_reg_sel;
      end
      if (state == 3'd4) begin
        wb_rf   = rf_we;
        wb_set  = pc_inc_or_set;
        wb_alu  = wb_reg_alu;
        wb_pcen = pc_en;
        done    = 1'b1;
      end
      step;
      cyc++;
    end
    if (!done) chk("run_bound", 0, 1);
  endtask

  initial begin
    reset = 1'b0;
    instruction = 16'h0;
    psr_flags = 5'h0;
    halt_req = 1'b0;
    mem_ready = 1'b0;
    step;
    step;
    chk("rst_state", state, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_pcen", pc_en, 0);
    chk("rst_rfwe", rf_we, 0);
    chk("rst_iren", ir_en, 0);
    chk("rst_pcsel", pc_reg_sel, 1);
    chk("rst_wbalu", wb_reg_alu, 1);
    reset = 1'b1;

    chk("fetch_req", mif.mem_req, 1);
    run(16'h51FD, 5'h00, 0, 1'b0);
    chk("addi_cyc", cyc, 4);
    chk("addi_ir", irn, 1);
    chk("addi_imm", ex_imm, 2'b01);
    chk("addi_psr", ex_psr, 1);
    chk("addi_r2", ex_r2, 1);
    chk("addi_rf", wb_rf, 1);
    chk("addi_pcen", wb_pcen, 1);
    chk("addi_set", wb_set, 0);
    chk("addi_next", state, 0);

    run(16'h4102, 5'h00, 3, 1'b0);
    chk("ld_cyc", cyc, 8);
    chk("ld_req", mreq_n, 4);
    chk("ld_we", mwe, 0);
    chk("ld_psr", ex_psr, 0);
    chk("ld_alu", wb_alu, 0);
    chk("ld_rf", wb_rf, 1);

    run(16'h40C3, 5'b01000, 0, 1'b0);
    chk("jeq_imm", ex_imm, 2'b11);
    chk("jeq_set", wb_set, 1);
    chk("jeq_rf", wb_rf, 0);
    run(16'h40C3, 5'b00000, 0, 1'b0);
    chk("jne_set", wb_set, 0);
    run(16'h4FC3, 5'b11111, 0, 1'b0);
    chk("jnv_set", wb_set, 0);

    run(16'hCA05, 5'b00000, 0, 1'b0);
    chk("blo_pcsel", ex_pcsel, 0);
    chk("blo_imm", ex_imm, 2'b01);
    chk("blo_set", wb_set, 1);
    chk("blo_rf", wb_rf, 0);
    run(16'hCB05, 5'b00000, 0, 1'b0);
    chk("bhs_set", wb_set, 0);

    run(16'hB105, 5'h00, 0, 1'b0);
    chk("cmpi_rf", wb_rf, 0);
    chk("cmpi_psr", ex_psr, 1);
    run(16'h01B2, 5'h00, 0, 1'b0);
    chk("cmp_rf", wb_rf, 0);
    run(16'h0152, 5'h00, 0, 1'b0);
    chk("add_r2", ex_r2, 0);
    chk("add_rf", wb_rf, 1);
    run(16'h1107, 5'h00, 0, 1'b0);
    chk("andi_imm", ex_imm, 2'b10);
    run(16'hF107, 5'h00, 0, 1'b0);
    chk("lui_imm", ex_imm, 2'b00);

    run(16'h4143, 5'h00, 1, 1'b1);
    chk("st_cyc", cyc, 6);
    chk("st_we", mwe, 1);
    chk("st_rf", wb_rf, 0);
    chk("st_halt", state, 5);
    chk("halt_req0", mif.mem_req, 0);
    step;
    chk("halt_hold", state, 5);
    chk("halt_pcen", pc_en, 0);
    halt_req = 1'b0;
    step;
    chk("halt_exit", state, 0);

    instruction = 16'h4102;
    mem_ready = 1'b1;
    step;
    step;
    mem_ready = 1'b0;
    step;
    chk("mid_mem", state, 3);
    step;
    reset = 1'b0;
    step;
    chk("mrst_state", state, 0);
    chk("mrst_rfwe", rf_we, 0);
    chk("mrst_pcen", pc_en, 0);
    chk("mrst_we", mif.mem_we, 0);
    chk("mrst_terr", timeout_err, 0);
    reset = 1'b1;

    mem_ready = 1'b0;
    halt_req = 1'b0;
    reset = 1'b0;
    step;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) step;
    chk("to_fetch", state, 0);
`ifdef CTRL_FSM_TIMEOUT_EN
    chk("to_reqdrop", mif.mem_req, 0);
    chk("to_err0", timeout_err, 0);
    step;
    chk("to_halt", state, 5);
    chk("to_err1", timeout_err, 1);
    step;
    step;
    chk("to_hold", state, 5);
    chk("to_sticky", timeout_err, 1);
`else
    step;
    step;
    chk("wait_state", state, 0);
    chk("wait_req", mif.mem_req, 1);
    chk("wait_terr", timeout_err, 0);
`endif

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
